// File: rtl/regfile_pkg.sv
// Shared definitions for the bypassing register file and its debug dump engine.
package regfile_pkg;

   // Dump engine states.
   typedef enum logic [1:0] {
      DUMP_IDLE = 2'd0,
      DUMP_RUN  = 2'd1,
      DUMP_DONE = 2'd2
   } dump_state_e;

   // Default $gp / $sp placement and reset contents.
   localparam int          GP_IDX_DEF  = 28;
   localparam logic [31:0] GP_INIT_DEF = 32'h10008000;
   localparam int          SP_IDX_DEF  = 29;
   localparam logic [31:0] SP_INIT_DEF = 32'h7ffffffc;

   // Widest word merge_bytes handles; callers cast their operands up and the result back down.
   localparam int MERGE_MAX_W  = 256;
   localparam int MERGE_MAX_BE = MERGE_MAX_W / 8;

   // Byte-granular merge: bytes with be set come from nw, the rest keep old_v.
   function automatic logic [MERGE_MAX_W-1:0] merge_bytes(
      input logic [MERGE_MAX_W-1:0]  old_v,
      input logic [MERGE_MAX_W-1:0]  nw,
      input logic [MERGE_MAX_BE-1:0] be
   );
      logic [MERGE_MAX_W-1:0] r;
      for (int k = 0; k < MERGE_MAX_BE; k++) begin
         r[8*k +: 8] = be[k] ? nw[8*k +: 8] : old_v[8*k +: 8];
      end
      return r;
   endfunction

endpackage

// File: rtl/regfile_dump_fsm.sv
// Dump sequencer: walks dump_idx from 0 to the last register under a valid/ready handshake.
module regfile_dump_fsm
   import regfile_pkg::*;
#(
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              dump_start,
   input  logic              dump_ready,
   output logic              dump_valid,
   output logic [ADDR_W-1:0] dump_idx,
   output logic              dump_busy,
   output logic              dump_done
);

   dump_state_e       state_q, state_d;
   logic [ADDR_W-1:0] idx_q, idx_d;

   // State and index registers; an asynchronous reset abandons any dump in progress.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= DUMP_IDLE;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

   // Next-state, index advance on each transfer, and handshake outputs.
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      dump_valid = 1'b0;
      dump_busy  = 1'b0;
      dump_done  = 1'b0;
      case (state_q)
         DUMP_IDLE: begin
            idx_d = '0;
            if (dump_start) state_d = DUMP_RUN;
         end
         DUMP_RUN: begin
            dump_valid = 1'b1;
            dump_busy  = 1'b1;
            if (dump_ready) begin
               // Register count is a power of two, so the last index is all ones.
               if (&idx_q) state_d = DUMP_DONE;
               else        idx_d   = idx_q + ADDR_W'(1);
            end
         end
         DUMP_DONE: begin
            dump_busy = 1'b1;
            dump_done = 1'b1;
            state_d   = DUMP_IDLE;
            idx_d     = '0;
         end
         default: begin
            state_d = DUMP_IDLE;
            idx_d   = '0;
         end
      endcase
   end

   assign dump_idx = idx_q;

endmodule

// File: rtl/regfile_bypass_dump.sv
// Register file with byte-enabled writes, optional write-to-read bypass and a debug dump port.
module regfile_bypass_dump
   import regfile_pkg::*;
#(
   parameter int                DATA_W  = 32,
   parameter int                NREG    = 32,
   parameter int                ADDR_W  = $clog2(NREG),
   parameter int                BYPASS  = 1,
   parameter int                GP_IDX  = GP_IDX_DEF,
   parameter logic [DATA_W-1:0] GP_INIT = DATA_W'(GP_INIT_DEF),
   parameter int                SP_IDX  = SP_IDX_DEF,
   parameter logic [DATA_W-1:0] SP_INIT = DATA_W'(SP_INIT_DEF)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                we,
   input  logic [DATA_W/8-1:0] wbe,
   input  logic [ADDR_W-1:0]   wa,
   input  logic [DATA_W-1:0]   wd,
   input  logic [ADDR_W-1:0]   ra1,
   input  logic [ADDR_W-1:0]   ra2,
   output logic [DATA_W-1:0]   rd1,
   output logic [DATA_W-1:0]   rd2,
   input  logic                dump_start,
   input  logic                dump_ready,
   output logic                dump_valid,
   output logic [ADDR_W-1:0]   dump_idx,
   output logic [DATA_W-1:0]   dump_data,
   output logic                dump_busy,
   output logic                dump_done
);

   logic [DATA_W-1:0] regs [NREG];
   logic              wr_en;
   logic [DATA_W-1:0] wr_merged;
   logic              hit1, hit2, hitd;

   // Register 0 is never written, so it keeps its cleared reset value.
   assign wr_en = we && (wa != '0);

   // The word that lands in regs[wa] at the edge; also the bypass value for any reader of wa.
   assign wr_merged = DATA_W'(merge_bytes(MERGE_MAX_W'(regs[wa]), MERGE_MAX_W'(wd),
                                          MERGE_MAX_BE'(wbe)));

   // Storage: preset $gp/$sp on reset, byte-merged update otherwise.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NREG; i++) begin
            if (i == GP_IDX)      regs[i] <= GP_INIT;
            else if (i == SP_IDX) regs[i] <= SP_INIT;
            else                  regs[i] <= '0;
         end
      end else if (wr_en) begin
         regs[wa] <= wr_merged;
      end
   end

   // A bypass hit requires a live write to the same non-zero address.
   assign hit1 = (BYPASS != 0) && wr_en && (wa == ra1);
   assign hit2 = (BYPASS != 0) && wr_en && (wa == ra2);
   assign hitd = (BYPASS != 0) && wr_en && (wa == dump_idx);

   assign rd1       = (ra1 == '0)      ? '0 : (hit1 ? wr_merged : regs[ra1]);
   assign rd2       = (ra2 == '0)      ? '0 : (hit2 ? wr_merged : regs[ra2]);
   assign dump_data = (dump_idx == '0) ? '0 : (hitd ? wr_merged : regs[dump_idx]);

   regfile_dump_fsm #(
      .ADDR_W (ADDR_W)
   ) u_dump_fsm (
      .clk        (clk),
      .reset      (reset),
      .dump_start (dump_start),
      .dump_ready (dump_ready),
      .dump_valid (dump_valid),
      .dump_idx   (dump_idx),
      .dump_busy  (dump_busy),
      .dump_done  (dump_done)
   );

endmodule
